// File: rtl/eth_mac_tx_ptp_sched_if.sv
// rtl/eth_mac_tx_ptp_sched_if.sv - requester, MAC tx_axis and timestamp-return bundle for eth_mac_tx_ptp_sched
interface eth_mac_tx_ptp_sched_if #(
  parameter int S_COUNT       = 4,
  parameter int DATA_WIDTH    = 128,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int PTP_TS_WIDTH  = 96,
  parameter int PTP_TAG_WIDTH = 16
);
  localparam int CL_S_COUNT = $clog2(S_COUNT);
  localparam int SEQ_WIDTH  = PTP_TAG_WIDTH - CL_S_COUNT;

  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [S_COUNT-1:0]            s_axis_tvalid;
  logic [S_COUNT-1:0]            s_axis_tready;
  logic [S_COUNT-1:0]            s_axis_tlast;
  logic [S_COUNT-1:0]            s_axis_tuser;

  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;
  logic [PTP_TAG_WIDTH:0]        m_axis_tuser;

  logic [PTP_TS_WIDTH-1:0]       s_axis_ts;
  logic [PTP_TAG_WIDTH-1:0]      s_axis_ts_tag;
  logic                          s_axis_ts_valid;
  logic                          s_axis_ts_ready;

  logic [PTP_TS_WIDTH-1:0]       m_axis_ts;
  logic [SEQ_WIDTH-1:0]          m_axis_ts_seq;
  logic [S_COUNT-1:0]            m_axis_ts_valid;
  logic [S_COUNT-1:0]            m_axis_ts_ready;

  logic [S_COUNT-1:0]            cfg_port_enable;
  logic                          stat_ts_drop;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready,
    output s_axis_ts, s_axis_ts_tag, s_axis_ts_valid,
    input  s_axis_ts_ready,
    input  m_axis_ts, m_axis_ts_seq, m_axis_ts_valid,
    output m_axis_ts_ready,
    output cfg_port_enable,
    input  stat_ts_drop
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready,
    input  s_axis_ts, s_axis_ts_tag, s_axis_ts_valid,
    output s_axis_ts_ready,
    output m_axis_ts, m_axis_ts_seq, m_axis_ts_valid,
    input  m_axis_ts_ready,
    input  cfg_port_enable,
    output stat_ts_drop
  );
endinterface

// File: rtl/eth_mac_tx_ptp_sched.sv
// rtl/eth_mac_tx_ptp_sched.sv - frame round-robin TX scheduler with PTP tag insertion and timestamp return steering
module eth_mac_tx_ptp_sched #(
  parameter int S_COUNT       = 4,
  parameter int DATA_WIDTH    = 128,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int PTP_TS_WIDTH  = 96,
  parameter int PTP_TAG_WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  eth_mac_tx_ptp_sched_if.slave bus
);
  localparam int CL_S_COUNT = $clog2(S_COUNT);
  localparam int SEQ_WIDTH  = PTP_TAG_WIDTH - CL_S_COUNT;
  localparam int CLW        = CL_S_COUNT + 1;

  typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic [CL_S_COUNT-1:0]   grant_q, grant_d;
  logic [CL_S_COUNT-1:0]   last_grant_q, last_grant_d;
  logic [SEQ_WIDTH-1:0]    seq_q [S_COUNT];
  logic [SEQ_WIDTH-1:0]    seq_d [S_COUNT];
  logic                    stat_ts_drop_q, stat_ts_drop_d;

  logic [S_COUNT-1:0]      req;
  logic                    req_found;
  logic [CL_S_COUNT-1:0]   req_pick;
  logic [CLW-1:0]          rr_idx;

  logic [DATA_WIDTH-1:0]   sel_tdata;
  logic [KEEP_WIDTH-1:0]   sel_tkeep;
  logic                    sel_tvalid;
  logic                    sel_tlast;
  logic                    sel_tuser;
  logic [SEQ_WIDTH-1:0]    sel_seq;
  logic [S_COUNT-1:0]      s_tready;

  logic [CL_S_COUNT-1:0]   ts_port;
  logic                    ts_hit;
  logic [S_COUNT-1:0]      ts_valid;
  logic                    ts_ready;

  // Cyclic search starting one past the last grant; the sum never reaches 2*S_COUNT.
  always_comb begin
    req       = bus.s_axis_tvalid & bus.cfg_port_enable;
    req_found = 1'b0;
    req_pick  = last_grant_q;
    rr_idx    = '0;
    for (int i = 1; i <= S_COUNT; i++) begin
      rr_idx = {1'b0, last_grant_q} + CLW'(i);
      if (rr_idx >= CLW'(S_COUNT)) rr_idx = rr_idx - CLW'(S_COUNT);
      if (!req_found && req[rr_idx[CL_S_COUNT-1:0]]) begin
        req_found = 1'b1;
        req_pick  = rr_idx[CL_S_COUNT-1:0];
      end
    end
  end

  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tuser  = 1'b0;
    sel_seq    = '0;
    s_tready   = '0;
    for (int p = 0; p < S_COUNT; p++) begin
      if (grant_q == CL_S_COUNT'(p)) begin
        sel_tdata   = bus.s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        sel_tkeep   = bus.s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tvalid  = bus.s_axis_tvalid[p];
        sel_tlast   = bus.s_axis_tlast[p];
        sel_tuser   = bus.s_axis_tuser[p];
        sel_seq     = seq_q[p];
        s_tready[p] = (state_q == ACTIVE) && bus.m_axis_tready;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    seq_d        = seq_q;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          grant_d      = req_pick;
          last_grant_d = req_pick;
          state_d      = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sel_tvalid && bus.m_axis_tready && sel_tlast) begin
          for (int p = 0; p < S_COUNT; p++) begin
            if (grant_q == CL_S_COUNT'(p)) seq_d[p] = seq_q[p] + SEQ_WIDTH'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tags whose port field is out of range are swallowed so the MAC FIFO never stalls.
  always_comb begin
    ts_port        = bus.s_axis_ts_tag[PTP_TAG_WIDTH-1 -: CL_S_COUNT];
    ts_hit         = 1'b0;
    ts_valid       = '0;
    ts_ready       = 1'b1;
    stat_ts_drop_d = 1'b0;
    for (int p = 0; p < S_COUNT; p++) begin
      if (ts_port == CL_S_COUNT'(p)) begin
        ts_hit      = 1'b1;
        ts_valid[p] = bus.s_axis_ts_valid;
        ts_ready    = bus.m_axis_ts_ready[p];
      end
    end
    if (!ts_hit) stat_ts_drop_d = bus.s_axis_ts_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_grant_q   <= CL_S_COUNT'(S_COUNT - 1);
      for (int p = 0; p < S_COUNT; p++) seq_q[p] <= '0;
      stat_ts_drop_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      seq_q          <= seq_d;
      stat_ts_drop_q <= stat_ts_drop_d;
    end
  end

  assign bus.m_axis_tdata    = sel_tdata;
  assign bus.m_axis_tkeep    = sel_tkeep;
  assign bus.m_axis_tvalid   = (state_q == ACTIVE) && sel_tvalid;
  assign bus.m_axis_tlast    = sel_tlast;
  assign bus.m_axis_tuser    = {grant_q, sel_seq, sel_tuser};
  assign bus.s_axis_tready   = s_tready;
  assign bus.s_axis_ts_ready = ts_ready;
  assign bus.m_axis_ts       = bus.s_axis_ts;
  assign bus.m_axis_ts_seq   = bus.s_axis_ts_tag[SEQ_WIDTH-1:0];
  assign bus.m_axis_ts_valid = ts_valid;
  assign bus.stat_ts_drop    = stat_ts_drop_q;
endmodule

// File: tb/tb_eth_mac_tx_ptp_sched.sv
// tb/tb_eth_mac_tx_ptp_sched.sv - directed scoreboard bench for eth_mac_tx_ptp_sched
module tb_eth_mac_tx_ptp_sched;
  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic         bad;
  } beat_t;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [16:0]  user;
    logic [1:0]   port;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_mac_tx_ptp_sched_if #(.S_COUNT(4)) bus4 ();
  eth_mac_tx_ptp_sched_if #(.S_COUNT(3)) bus3 ();

  eth_mac_tx_ptp_sched #(.S_COUNT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  eth_mac_tx_ptp_sched #(.S_COUNT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        mac_rdy = 1'b1;
  bit          tog = 1'b0;
  bit          mon_en = 1'b0;
  beat_t       src_q [4][$];
  exp_t        exp_q [$];
  int          beat_cyc [$];
  logic [16:0] beat_user [$];
  logic [13:0] exp_seq [4];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int p = 0; p < 4; p++) begin
      if (src_q[p].size() > 0) begin
        b = src_q[p][0];
        bus4.s_axis_tdata[p*128 +: 128] = b.data;
        bus4.s_axis_tkeep[p*16 +: 16]   = b.keep;
        bus4.s_axis_tvalid[p]           = 1'b1;
        bus4.s_axis_tlast[p]            = b.last;
        bus4.s_axis_tuser[p]            = b.bad;
      end else begin
        bus4.s_axis_tvalid[p] = 1'b0;
        bus4.s_axis_tlast[p]  = 1'b0;
      end
    end
    bus4.m_axis_tready = mac_rdy;
  endtask

  task automatic push_frame(input int port, input int nbeats, input logic bad, input int nexp);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.last = (i == nbeats - 1);
      b.keep = b.last ? 16'($urandom_range(1, 65535)) : 16'hffff;
      b.bad  = bad;
      src_q[port].push_back(b);
      if (i < nexp) begin
        e.data = b.data;
        e.keep = b.keep;
        e.last = b.last;
        e.user = {2'(port), exp_seq[port], bad};
        e.port = 2'(port);
        exp_q.push_back(e);
      end
    end
    if (nexp == nbeats) exp_seq[port] = exp_seq[port] + 14'd1;
  endtask

  task automatic mon();
    exp_t       e;
    logic [3:0] mask;
    mask = 4'b0000;
    if (exp_q.size() > 0) mask = 4'(1 << exp_q[0].port);
    check("tready_grant_only", bus4.s_axis_tready & ~mask, 0);
    if (bus4.m_axis_tvalid === 1'b1 && bus4.m_axis_tready === 1'b1) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat", {bus4.m_axis_tdata, bus4.m_axis_tkeep, bus4.m_axis_tlast, bus4.m_axis_tuser},
              {e.data, e.keep, e.last, e.user});
        beat_cyc.push_back(cyc);
        beat_user.push_back(bus4.m_axis_tuser);
      end
    end
  endtask

  task automatic tick();
    logic [3:0] fire;
    @(negedge clk);
    fire = bus4.s_axis_tvalid & bus4.s_axis_tready;
    if (mon_en) mon();
    @(posedge clk);
    cyc++;
    #1;
    for (int p = 0; p < 4; p++) begin
      if (fire[p] === 1'b1 && src_q[p].size() > 0) src_q[p].delete(0);
    end
    if (tog) mac_rdy = ~mac_rdy;
    drive();
  endtask

  task automatic run_until_empty(input int maxc, input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    for (int p = 0; p < 4; p++) src_q[p].delete();
    exp_q.delete();
    exp_seq = '{default: '0};
    mac_rdy = 1'b1;
    tog = 1'b0;
    drive();
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    int          c0;
    int          n;
    logic [16:0] u;

    bus4.s_axis_tdata    = '0;
    bus4.s_axis_tkeep    = '0;
    bus4.s_axis_tvalid   = '0;
    bus4.s_axis_tlast    = '0;
    bus4.s_axis_tuser    = '0;
    bus4.m_axis_tready   = 1'b1;
    bus4.s_axis_ts       = '0;
    bus4.s_axis_ts_tag   = '0;
    bus4.s_axis_ts_valid = 1'b0;
    bus4.m_axis_ts_ready = 4'b1111;
    bus4.cfg_port_enable = 4'b1111;
    bus3.s_axis_tdata    = '0;
    bus3.s_axis_tkeep    = '0;
    bus3.s_axis_tvalid   = '0;
    bus3.s_axis_tlast    = '0;
    bus3.s_axis_tuser    = '0;
    bus3.m_axis_tready   = 1'b1;
    bus3.s_axis_ts       = '0;
    bus3.s_axis_ts_tag   = '0;
    bus3.s_axis_ts_valid = 1'b0;
    bus3.m_axis_ts_ready = 3'b111;
    bus3.cfg_port_enable = 3'b111;

    do_reset();
    check("rst_tready", bus4.s_axis_tready, 0);
    check("rst_tvalid", bus4.m_axis_tvalid, 0);
    check("rst_drop", bus4.stat_ts_drop, 0);
    check("rst3_tready", bus3.s_axis_tready, 0);
    check("rst3_tvalid", bus3.m_axis_tvalid, 0);
    check("rst3_drop", bus3.stat_ts_drop, 0);

    // single port, 3 beats then a second frame
    beat_cyc.delete();
    beat_user.delete();
    push_frame(2, 3, 1'b0, 3);
    c0 = cyc;
    drive();
    run_until_empty(20, "single1");
    check("single_nbeats", beat_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < beat_cyc.size()) check("single_beat_cycle", beat_cyc[i], c0 + 1 + i);
    end
    if (beat_user.size() > 0) check("single_tuser", beat_user[0], 17'h10000);
    push_frame(2, 1, 1'b1, 1);
    drive();
    run_until_empty(20, "single2");
    if (beat_user.size() > 3) check("single_seq1", beat_user[3], 17'h10003);

    // all four ports contending, two frames each
    do_reset();
    beat_cyc.delete();
    beat_user.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) push_frame(p, 2, 1'b0, 2);
    c0 = cyc;
    drive();
    run_until_empty(100, "contend");
    check("contend_nbeats", beat_cyc.size(), 16);
    for (int k = 0; k < 16; k++) begin
      if (k < beat_cyc.size()) check("contend_beat_cycle", beat_cyc[k], c0 + 1 + 3 * (k / 2) + (k % 2));
    end
    push_frame(0, 1, 1'b0, 1);
    push_frame(3, 1, 1'b0, 1);
    drive();
    run_until_empty(20, "contend_seq2");
    if (beat_user.size() > 17) begin
      u = beat_user[16];
      check("port0_seq2", u[14:1], 2);
      u = beat_user[17];
      check("port3_seq2", u[14:1], 2);
    end

    // backpressure: MAC ready toggles 1,0,1,0 across a 5-beat frame
    push_frame(1, 5, 1'b0, 5);
    mac_rdy = 1'b1;
    tog = 1'b1;
    drive();
    run_until_empty(40, "bp");
    tog = 1'b0;
    mac_rdy = 1'b1;
    check("bp_src_drained", src_q[1].size(), 0);
    drive();

    // enable mask 1011: port 2 requests but must never be granted
    bus4.cfg_port_enable = 4'b1011;
    push_frame(2, 1, 1'b0, 0);
    push_frame(3, 1, 1'b0, 1);
    push_frame(0, 1, 1'b0, 1);
    push_frame(1, 1, 1'b0, 1);
    drive();
    run_until_empty(40, "mask");
    for (int i = 0; i < 5; i++) tick();
    check("mask_port2_pending", src_q[2].size(), 1);
    check("mask_no_tvalid", bus4.m_axis_tvalid, 0);
    src_q[2].delete();
    bus4.cfg_port_enable = 4'b1111;
    drive();

    // sequence wrap: 2^14 frames from port 0, then one more
    do_reset();
    beat_user.delete();
    for (int k = 0; k < 16385; k++) push_frame(0, 1, 1'b0, 1);
    drive();
    run_until_empty(40000, "wrap");
    if (beat_user.size() == 16385) begin
      u = beat_user[16383];
      check("wrap_seq_max", u[14:1], 14'h3fff);
      u = beat_user[16384];
      check("wrap_seq_zero", u[14:1], 0);
    end else begin
      check("wrap_nframes", beat_user.size(), 16385);
    end

    // timestamp routing to port 1 with backpressure
    bus4.s_axis_ts       = 96'h0123_4567_89ab_cdef_0246_8ace;
    bus4.s_axis_ts_tag   = 16'h4005;
    bus4.s_axis_ts_valid = 1'b1;
    bus4.m_axis_ts_ready = 4'b1101;
    @(negedge clk);
    check("ts_valid_p1", bus4.m_axis_ts_valid, 4'b0010);
    check("ts_ready_held", bus4.s_axis_ts_ready, 0);
    check("ts_seq", bus4.m_axis_ts_seq, 5);
    check("ts_data", bus4.m_axis_ts, 96'h0123_4567_89ab_cdef_0246_8ace);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ts_valid_hold", bus4.m_axis_ts_valid, 4'b0010);
    check("ts_ready_hold", bus4.s_axis_ts_ready, 0);
    @(posedge clk);
    #1;
    bus4.m_axis_ts_ready = 4'b1111;
    @(negedge clk);
    check("ts_ready_rise", bus4.s_axis_ts_ready, 1);
    @(posedge clk);
    #1;
    bus4.s_axis_ts_valid = 1'b0;
    @(negedge clk);
    check("ts_valid_clear", bus4.m_axis_ts_valid, 0);
    check("ts_no_drop", bus4.stat_ts_drop, 0);

    // out-of-range tag on the 3-port instance
    @(posedge clk);
    #1;
    bus3.s_axis_ts_tag   = 16'hc000;
    bus3.s_axis_ts_valid = 1'b1;
    bus3.m_axis_ts_ready = 3'b000;
    @(negedge clk);
    check("drop_ready", bus3.s_axis_ts_ready, 1);
    check("drop_no_valid", bus3.m_axis_ts_valid, 0);
    check("drop_not_yet", bus3.stat_ts_drop, 0);
    @(posedge clk);
    #1;
    bus3.s_axis_ts_valid = 1'b0;
    @(negedge clk);
    check("drop_pulse", bus3.stat_ts_drop, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("drop_pulse_end", bus3.stat_ts_drop, 0);
    @(posedge clk);
    #1;

    // reset asserted while beat 2 of 4 is on the bus
    push_frame(0, 4, 1'b0, 2);
    drive();
    n = 0;
    while (exp_q.size() > 1 && n < 10) begin
      tick();
      n++;
    end
    check("rstmid_beat1", exp_q.size(), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_beat2", exp_q.size(), 0);
    src_q[0].delete();
    exp_seq = '{default: '0};
    drive();
    @(negedge clk);
    check("rstmid_tvalid", bus4.m_axis_tvalid, 0);
    check("rstmid_tready", bus4.s_axis_tready, 0);
    @(posedge clk);
    cyc++;
    #1;
    beat_user.delete();
    push_frame(0, 1, 1'b0, 1);
    drive();
    run_until_empty(20, "rstmid_next");
    if (beat_user.size() > 0) begin
      u = beat_user[0];
      check("rstmid_seq0", u[14:1], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_mac_tx_ptp_sched.md
# eth_mac_tx_ptp_sched

Frame-granular round-robin scheduler that lets several AXI-stream TX requesters share one 10G/40G MAC-with-FIFO transmit path. For each frame it assigns a PTP tag `{port index, per-port sequence number}` and drives the tag into the MAC tx_axis_tuser. It also steers the returned TX timestamps from the MAC timestamp FIFO back to the requester that sent the frame. It runs in the logic clock domain, between the requesters and the MAC's tx_axis / m_axis_tx_ptp_ts ports.

## Interface
- S_COUNT, 4: number of requesters (2–16).
- DATA_WIDTH, 128: tdata width.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- PTP_TS_WIDTH, 96: timestamp width.
- PTP_TAG_WIDTH, 16: tag width.
- CL_S_COUNT (localparam), $clog2(S_COUNT): port field width.
- SEQ_WIDTH (localparam), PTP_TAG_WIDTH-CL_S_COUNT: sequence field width.

Ports:
- clk  in  1  logic clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  per-port data.
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  per-port keep.
- s_axis_tvalid  in  S_COUNT  per-port valid.
- s_axis_tready  out  S_COUNT  per-port ready.
- s_axis_tlast  in  S_COUNT  per-port last.
- s_axis_tuser  in  S_COUNT  per-port bad-frame flag.
- m_axis_tdata/tkeep/tvalid/tlast  out  DATA_WIDTH/KEEP_WIDTH/1/1  to MAC tx_axis.
- m_axis_tready  in  1  from MAC tx_axis_tready.
- m_axis_tuser  out  PTP_TAG_WIDTH+1  `{tag, bad}`; bit 0 is bad.
- s_axis_ts  in  PTP_TS_WIDTH  timestamp from the MAC.
- s_axis_ts_tag  in  PTP_TAG_WIDTH  tag from the MAC.
- s_axis_ts_valid  in  1  timestamp valid.
- s_axis_ts_ready  out  1  timestamp ready.
- m_axis_ts  out  PTP_TS_WIDTH  timestamp, broadcast to all ports.
- m_axis_ts_seq  out  SEQ_WIDTH  sequence field of the returned tag.
- m_axis_ts_valid  out  S_COUNT  per-port timestamp valid.
- m_axis_ts_ready  in  S_COUNT  per-port timestamp ready.
- cfg_port_enable  in  S_COUNT  grant mask.
- stat_ts_drop  out  1  one-cycle pulse when a timestamp tag is invalid.

## Operation
- **FSM states:** IDLE, ACTIVE. Registers: grant (CL_S_COUNT bits), last_grant, and seq[S_COUNT] (SEQ_WIDTH bits each).
- **IDLE:**
  - req = s_axis_tvalid & cfg_port_enable.
  - If req ≠ 0: grant ← first set bit of req, searching cyclically from last_grant+1 (mod S_COUNT); last_grant ← same value; go to ACTIVE.
  - All s_axis_tready = 0 and m_axis_tvalid = 0 while in IDLE.
- **ACTIVE:** combinational pass-through from port g = grant.
  - m_axis_tdata/tkeep/tlast/tvalid = port g fields.
  - m_axis_tuser = `{g, seq[g], s_axis_tuser[g]}`.
  - s_axis_tready[g] = m_axis_tready; all other ready bits are 0.
  - On a transfer (tvalid & tready) with tlast: seq[g] ← seq[g]+1, wrapping mod 2^SEQ_WIDTH; go to IDLE.
- **Enable changes:** clearing cfg_port_enable[g] mid-frame does not abort the frame. The mask only affects grant selection in IDLE.
- **Timestamp return:** combinational, independent of the FSM.
  - p = s_axis_ts_tag[PTP_TAG_WIDTH-1 -: CL_S_COUNT].
  - If p < S_COUNT: m_axis_ts_valid[p] = s_axis_ts_valid and s_axis_ts_ready = m_axis_ts_ready[p].
  - Otherwise: s_axis_ts_ready = 1, all m_axis_ts_valid = 0, and stat_ts_drop is asserted (registered) for the cycle after the drop.
  - m_axis_ts = s_axis_ts; m_axis_ts_seq = low SEQ_WIDTH bits of the tag.

## Timing
- **Reset values:**
  - state = IDLE, grant = 0, last_grant = S_COUNT-1 (port 0 has first priority), all seq = 0.
  - Outputs: s_axis_tready = 0, m_axis_tvalid = 0, stat_ts_drop = 0.
- **Arbitration latency:** the first beat can reach the MAC 1 cycle after tvalid rises in IDLE. Each frame ends with one IDLE bubble cycle, so back-to-back frames are separated by exactly 1 idle cycle.
- **Data path latency:** 0 cycles in ACTIVE; tdata is not registered.
- **Backpressure:** a stall holds the current beat with no loss and no duplication. Requesters must hold tvalid and data stable until ready (AXI-stream rule).
- **Fairness:** with all ports continuously requesting, grant order is 0,1,…,S_COUNT-1,0; no port waits more than S_COUNT-1 frames.
- **Concurrency:** a timestamp return and a frame transfer in the same cycle are independent. A sequence increment and a timestamp with the same seq do not interact.
- **Reset mid-frame:** rst wins. The FSM returns to IDLE and the partially sent frame is truncated with no tlast. Counters clear.

## Test plan
- **Single port:** port 2 sends a 3-beat frame with m_axis_tready = 1. Required: beats appear on cycles 1–3 after tvalid, and m_axis_tuser = `{2'd2, 14'd0, 1'b0}`. A second frame carries seq = 1.
- **All ports contending:** all 4 ports send 2 frames each. Required: grant order 0,1,2,3,0,1,2,3, one idle cycle between frames, and each port's seq reaches 2.
- **Backpressure:** m_axis_tready toggles 1010 during a 5-beat frame. Required: output data equals input with no duplicate or lost beats, and ready appears only on the granted port.
- **Enable mask and wrap:** cfg_port_enable = 4'b1011 with port 2 requesting. Required: port 2 is never granted. Then 2^14 frames from port 0. Required: seq wraps to 0.
- **Timestamp routing:**
  - Tag 0x4005 with m_axis_ts_ready[1] = 0. Required: m_axis_ts_valid = 4'b0010 and s_axis_ts_ready = 0 until ready rises; m_axis_ts_seq = 5.
  - With S_COUNT = 3, tag 0xC000. Required: accepted immediately and a one-cycle stat_ts_drop pulse.
- **Reset mid-frame:** rst pulsed on beat 2 of 4. Required: the next cycle shows tvalid = 0, tready = 0, and the next frame from port 0 carries seq = 0.
